// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: skid-register state encoding and payload widths.
package pipe_pkg;

   // Occupancy state of a pipe_skid_reg instance.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_e;

   // NOP encoding used as the bubble in instruction-carrying stages.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Payload widths for the {PC, Instr} fetch/decode payload.
   localparam int PC_W    = 32;
   localparam int INSTR_W = 32;
   localparam int FD_W    = PC_W + INSTR_W;

   // Number of entries held in a given state.
   function automatic logic [1:0] occupancy_of(input skid_state_e st);
      logic [1:0] occ;
      occ = 2'd0;
      case (st)
         EMPTY:   occ = 2'd0;
         ONE:     occ = 2'd1;
         FULL:    occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage : pipe_pkg

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer.
// up_ready depends only on registered state, so there is no combinational
// path from dn_ready back to up_ready. All outputs come straight from flops.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int                 DATA_W = 64,
   parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}},
   parameter int                 CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              up_valid,
   output logic              up_ready,
   input  logic [DATA_W-1:0] up_data,
   output logic              dn_valid,
   input  logic              dn_ready,
   output logic [DATA_W-1:0] dn_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   skid_state_e       state_reg, state_next;
   logic [DATA_W-1:0] main_reg, main_next;
   logic [DATA_W-1:0] skid_reg, skid_next;
   logic              up_ready_reg;
   logic              dn_valid_reg;
   logic [1:0]        occupancy_reg;
   logic [CNT_W-1:0]  stall_cnt_reg;

   logic up_fire;

   assign up_fire = up_valid & up_ready_reg;

   // Next-state and datapath decode; flush has priority over any transfer.
   // The head register is reloaded with BUBBLE whenever the buffer empties,
   // so dn_data can be driven directly from the head flop.
   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_next  = skid_reg;
      if (flush) begin
         state_next = EMPTY;
         main_next  = BUBBLE;
         skid_next  = BUBBLE;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (up_fire) begin
                  state_next = ONE;
                  main_next  = up_data;
               end
            end
            ONE: begin
               if (up_fire && dn_ready) begin
                  main_next = up_data;
               end else if (up_fire) begin
                  state_next = FULL;
                  skid_next  = up_data;
               end else if (dn_ready) begin
                  state_next = EMPTY;
                  main_next  = BUBBLE;
               end
            end
            FULL: begin
               if (dn_ready) begin
                  state_next = ONE;
                  main_next  = skid_reg;
                  skid_next  = BUBBLE;
               end
            end
            default: begin
               state_next = EMPTY;
               main_next  = BUBBLE;
               skid_next  = BUBBLE;
            end
         endcase
      end
   end

   // State, payload registers and handshake outputs registered from next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= EMPTY;
         main_reg      <= BUBBLE;
         skid_reg      <= BUBBLE;
         up_ready_reg  <= 1'b1;
         dn_valid_reg  <= 1'b0;
         occupancy_reg <= 2'd0;
      end else begin
         state_reg     <= state_next;
         main_reg      <= main_next;
         skid_reg      <= skid_next;
         up_ready_reg  <= (state_next != FULL);
         dn_valid_reg  <= (state_next != EMPTY);
         occupancy_reg <= occupancy_of(state_next);
      end
   end

   // Saturating count of cycles where downstream holds off a valid head;
   // flush leaves it alone so stall history survives pipeline redirects.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_reg <= '0;
      end else if (dn_valid_reg && !dn_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
   end

   assign up_ready  = up_ready_reg;
   assign dn_valid  = dn_valid_reg;
   assign dn_data   = main_reg;
   assign occupancy = occupancy_reg;
   assign stall_cnt = stall_cnt_reg;

endmodule : pipe_skid_reg

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised inter-stage pipeline register that replaces the fixed F/D-style registers. It carries an opaque payload of DATA_W bits, such as {PC, Instr}, under a valid/ready handshake. A 2-entry skid buffer gives full throughput with no combinational path from dn_ready to up_ready. Flush inserts a bubble, and a saturating stall counter supports performance debug. One instance sits between each pair of pipeline stages (F/D, D/E, E/M, M/W).

Parameters:
DATA_W, 64, payload width in bits.
BUBBLE, {DATA_W{1'b0}}, value driven on dn_data whenever dn_valid=0 (NOP encoding).
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
flush  in  1  synchronous clear of all held entries.
up_valid  in  1  upstream payload valid.
up_ready  out  1  stage can accept; registered.
up_data  in  DATA_W  upstream payload.
dn_valid  out  1  payload available downstream.
dn_ready  in  1  downstream accepts.
dn_data  out  DATA_W  head payload, or BUBBLE when dn_valid=0.
occupancy  out  2  entries held (0..2).
stall_cnt  out  CNT_W  cycles with dn_valid=1 and dn_ready=0; saturating.

Behaviour:
- Handshakes: up_fire = up_valid & up_ready; dn_fire = dn_valid & dn_ready. Transfers occur only on fire.
- Storage:
  - main register: the head, drives dn_data.
  - skid register: second entry.
  - state is one of EMPTY, ONE, FULL.
- Output decode:
  - dn_valid = (state != EMPTY).
  - up_ready = (state != FULL); decoded from registered state only, never from dn_ready or up_valid.
  - occupancy: 0 / 1 / 2 for EMPTY / ONE / FULL.
  - dn_data = main when dn_valid, else BUBBLE.
- Reset (reset=0, asynchronous): state=EMPTY, main=skid=BUBBLE, stall_cnt=0. Resulting outputs: up_ready=1, dn_valid=0, dn_data=BUBBLE, occupancy=0. Reset mid-transfer discards all data.
- Transitions at posedge clk, evaluated in priority order:
  - flush=1: state->EMPTY, main=skid=BUBBLE. A simultaneous up_fire is dropped; flush wins. A simultaneous dn_fire still counts as consumed by downstream in that cycle.
  - EMPTY: up_fire -> ONE, main<=up_data. Otherwise hold.
  - ONE:
    - up_fire & dn_ready -> ONE, main<=up_data (pass-through, 1 per cycle).
    - up_fire & !dn_ready -> FULL, skid<=up_data.
    - !up_fire & dn_ready -> EMPTY.
    - Otherwise hold.
  - FULL: up_ready=0, so no up_fire is possible. dn_ready -> ONE, main<=skid. Otherwise hold.
- Latency and ordering:
  - Latency is 1 cycle from up_fire to dn_valid when EMPTY.
  - Order is strictly FIFO; no duplication or loss except on flush/reset.
  - Sustained throughput is 1 transfer per cycle with dn_ready held high.
- Payload in a held register stays bit-stable while not fired.
- stall_cnt:
  - Increments when dn_valid & !dn_ready and the count is below 2^CNT_W-1.
  - Saturates at all-ones.
  - Cleared only by reset; flush does not clear it.
- up_valid with up_ready=0 has no effect.

Decomposition:
- Shared package pipe_pkg:
  - state enum (EMPTY=2'd0, ONE=2'd1, FULL=2'd2).
  - NOP_INSTR=32'h0000_0000.
  - Payload width constants: PC_W=32, INSTR_W=32, FD_W=64.
- No sub-module. The stall counter stays inline, since it is under 15 lines.
- Instruction field slicing (rs/rt/imm/index) is done by the consumer stage, not in this block.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release -> up_ready=1, dn_valid=0, dn_data=0, occupancy=0, stall_cnt=0.
- Streaming: up_valid=1, dn_ready=1, up_data=0x3000+4k for k=0..7.
  - dn_data shows 0x3000..0x301C, one per cycle, with 1-cycle latency.
  - occupancy stays 1 and up_ready stays 1.
- Backpressure/skid: push A=0x11, B=0x22 with dn_ready=0.
  - occupancy=2, up_ready=0, dn_data=0x11 held stable.
  - stall_cnt increments each stalled cycle.
  - Raise dn_ready -> 0x11 then 0x22 delivered, occupancy 2->1->0.
- Flush: in FULL, assert flush together with up_valid=1, up_data=0x33.
  - Next cycle: dn_valid=0, dn_data=BUBBLE, occupancy=0, up_ready=1.
  - 0x33 never appears downstream.
- Async reset mid-operation: in FULL, drive reset=0 between clock edges.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - stall_cnt=0.
- Saturation: with CNT_W=4, stall for 20 cycles -> stall_cnt=15 and holds; no wrap to 0.
